// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// The loader takes a host byte stream and writes it into the instruction memory.
package imem_loader_pkg;

  localparam int ADDR_W_DEFAULT = 8;
  localparam int DATA_W_FIXED   = 16;
  localparam int WORD_BYTES     = 2;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LEN  = 3'd1,
    ST_HI   = 3'd2,
    ST_LO   = 3'd3,
    ST_CHK  = 3'd4,
    ST_DONE = 3'd5,
    ST_ERR  = 3'd6
  } state_e;

  // Running frame checksum: plain XOR over the data bytes
  function automatic logic [7:0] chk_fold(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

  function automatic logic is_receiving(input state_e s);
    logic r;
    case (s)
      ST_LEN, ST_HI, ST_LO, ST_CHK: r = 1'b1;
      default:                      r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Host byte stream plus instruction-memory write port and CPU status.
// The master side is the host; the slave side is the loader.
interface imem_loader_if
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT
);
  logic                    start;
  logic                    in_valid;
  logic [7:0]              in_byte;
  logic                    in_ready;
  logic                    wr_en;
  logic [ADDR_W-1:0]       wr_addr;
  logic [DATA_W_FIXED-1:0] wr_data;
  logic                    cpu_hold;
  logic                    done;
  logic                    error;

  modport master (
    output start, in_valid, in_byte,
    input  in_ready, wr_en, wr_addr, wr_data, cpu_hold, done, error
  );

  modport slave (
    input  start, in_valid, in_byte,
    output in_ready, wr_en, wr_addr, wr_data, cpu_hold, done, error
  );
endinterface

// File: rtl/imem_loader.sv
// Receives LEN / data words / CHK frames and writes the words into instruction memory,
// holding the CPU in reset until a frame with a good checksum has been loaded.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT,
  parameter int DATA_W = DATA_W_FIXED
) (
  input  logic          clk,
  input  logic          reset,
  imem_loader_if.slave  bus
);

  if (DATA_W != DATA_W_FIXED) begin : g_bad_data_w
    $error("imem_loader: DATA_W must be 16");
  end

  state_e              state_q, state_d;
  logic [7:0]          hi_q, hi_d;
  logic [7:0]          chk_q, chk_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [ADDR_W-1:0]   last_q, last_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic                in_ready_q, in_ready_d;
  logic                cpu_hold_q, cpu_hold_d;
  logic                done_q, done_d;
  logic                error_q, error_d;
  logic                xfer;

  // in_ready_q always mirrors "state is LEN/HI/LO/CHK", so it gates the transfer directly
  assign xfer = bus.in_valid & in_ready_q;

  // Next-state, datapath and status decode
  always_comb begin
    state_d   = state_q;
    hi_d      = hi_q;
    chk_d     = chk_q;
    idx_d     = idx_q;
    last_d    = last_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (bus.start) begin
          state_d = ST_LEN;
          chk_d   = 8'h00;
          idx_d   = '0;
        end else begin
          state_d = state_q;
        end
      end
      ST_LEN: begin
        if (xfer) begin
          // LEN=0 encodes a full address-space frame
          last_d  = (bus.in_byte == 8'd0) ? {ADDR_W{1'b1}} : ADDR_W'(bus.in_byte - 8'd1);
          state_d = ST_HI;
        end else begin
          state_d = ST_LEN;
        end
      end
      ST_HI: begin
        if (xfer) begin
          hi_d    = bus.in_byte;
          chk_d   = chk_fold(chk_q, bus.in_byte);
          state_d = ST_LO;
        end else begin
          state_d = ST_HI;
        end
      end
      ST_LO: begin
        if (xfer) begin
          chk_d     = chk_fold(chk_q, bus.in_byte);
          wr_en_d   = 1'b1;
          wr_addr_d = idx_q;
          wr_data_d = {hi_q, bus.in_byte};
          if (idx_q == last_q) begin
            state_d = ST_CHK;
          end else begin
            idx_d   = idx_q + ADDR_W'(1);
            state_d = ST_HI;
          end
        end else begin
          state_d = ST_LO;
        end
      end
      ST_CHK: begin
        if (xfer) begin
          state_d = (bus.in_byte == chk_q) ? ST_DONE : ST_ERR;
        end else begin
          state_d = ST_CHK;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    in_ready_d = is_receiving(state_d);
    cpu_hold_d = (state_d != ST_DONE);
    done_d     = (state_d == ST_DONE);
    error_d    = (state_d == ST_ERR);
  end

  // State and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      hi_q       <= 8'h00;
      chk_q      <= 8'h00;
      idx_q      <= '0;
      last_q     <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      in_ready_q <= 1'b0;
      cpu_hold_q <= 1'b1;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      hi_q       <= hi_d;
      chk_q      <= chk_d;
      idx_q      <= idx_d;
      last_q     <= last_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      in_ready_q <= in_ready_d;
      cpu_hold_q <= cpu_hold_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  assign bus.in_ready = in_ready_q;
  assign bus.wr_en    = wr_en_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_data  = wr_data_q;
  assign bus.cpu_hold = cpu_hold_q;
  assign bus.done     = done_q;
  assign bus.error    = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed frames plus randomized frames,
// checked against a frame-level model of expected writes and final status.
module tb_imem_loader;

  logic clk;
  logic reset;

  imem_loader_if #(.ADDR_W(8)) bus();

  imem_loader #(.ADDR_W(8), .DATA_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_tests;
  int n_fail;
  int wr_count;
  logic prev_wr;
  logic [7:0]  pend_addr;
  logic [15:0] pend_data;
  logic [7:0]  data_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock; sample #1 after the edge and check the write port
  task automatic step(input logic exp_wr);
    @(posedge clk);
    #1;
    chk_eq("wr_en", 32'(bus.wr_en), 32'(exp_wr));
    if (bus.wr_en === 1'b1) begin
      wr_count++;
      chk_eq("wr_consec", 32'(prev_wr), 32'd0);
      chk_eq("wr_addr", 32'(bus.wr_addr), 32'(pend_addr));
      chk_eq("wr_data", 32'(bus.wr_data), 32'(pend_data));
    end
    prev_wr = bus.wr_en;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    step(1'b0);
    bus.start = 1'b0;
    chk_eq("start_ready", 32'(bus.in_ready), 32'd1);
    chk_eq("start_done", 32'(bus.done), 32'd0);
    chk_eq("start_error", 32'(bus.error), 32'd0);
    chk_eq("start_hold", 32'(bus.cpu_hold), 32'd1);
  endtask

  // mode 0: valid held high; 1: valid toggles each cycle; 2: random idle gaps
  task automatic send_byte(input logic [7:0] b, input logic is_lo, input int mode,
                           input logic with_start);
    logic acc;
    int   tries;
    if (mode == 2) begin
      repeat ($urandom_range(0, 2)) step(1'b0);
    end
    bus.in_valid = 1'b1;
    bus.in_byte  = b;
    bus.start    = with_start;
    acc   = 1'b0;
    tries = 0;
    while (!acc && tries < 16) begin
      acc = bus.in_ready;
      step(acc && is_lo);
      bus.start = 1'b0;
      tries++;
    end
    chk_eq("accepted", 32'(acc), 32'd1);
    if (mode == 0) begin
      chk_eq("no_bubble", 32'(tries), 32'd1);
    end
    bus.in_valid = 1'b0;
    bus.in_byte  = 8'($urandom);
    if (mode == 1) begin
      step(1'b0);
    end
  endtask

  // Whole frame from data_q; expected writes and status come from the frame contents
  task automatic run_frame(input logic [7:0] len, input logic [7:0] chk_byte,
                           input int mode, input logic mid_start);
    int n;
    logic [7:0] x;
    logic good;
    n = (len == 8'd0) ? 256 : int'(len);
    x = 8'h00;
    for (int i = 0; i < 2 * n; i++) x = x ^ data_q[i];
    good = (chk_byte == x);
    pulse_start();
    wr_count = 0;
    send_byte(len, 1'b0, mode, 1'b0);
    for (int w = 0; w < n; w++) begin
      send_byte(data_q[2*w], 1'b0, mode, mid_start && (w == 0));
      pend_addr = 8'(w);
      pend_data = {data_q[2*w], data_q[2*w+1]};
      send_byte(data_q[2*w+1], 1'b1, mode, 1'b0);
    end
    send_byte(chk_byte, 1'b0, mode, 1'b0);
    chk_eq("write_count", 32'(wr_count), 32'(n));
    chk_eq("done", 32'(bus.done), 32'(good));
    chk_eq("error", 32'(bus.error), 32'(!good));
    chk_eq("cpu_hold", 32'(bus.cpu_hold), 32'(!good));
    chk_eq("ready_end", 32'(bus.in_ready), 32'd0);
  endtask

  initial begin
    logic [7:0] len;
    logic [7:0] x;
    n_tests      = 0;
    n_fail       = 0;
    wr_count     = 0;
    prev_wr      = 1'b0;
    pend_addr    = 8'h00;
    pend_data    = 16'h0000;
    reset        = 1'b1;
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_byte  = 8'h00;

    #1;
    chk_eq("rst_ready", 32'(bus.in_ready), 32'd0);
    chk_eq("rst_wr_en", 32'(bus.wr_en), 32'd0);
    chk_eq("rst_wr_addr", 32'(bus.wr_addr), 32'd0);
    chk_eq("rst_wr_data", 32'(bus.wr_data), 32'd0);
    chk_eq("rst_hold", 32'(bus.cpu_hold), 32'd1);
    chk_eq("rst_done", 32'(bus.done), 32'd0);
    chk_eq("rst_error", 32'(bus.error), 32'd0);
    step(1'b0);
    step(1'b0);
    reset = 1'b0;
    step(1'b0);

    // Basic good frame, back-to-back
    data_q = '{8'h12, 8'h34, 8'hAB, 8'hCD};
    run_frame(8'h02, 8'h40, 0, 1'b0);

    // Same frame with a bad checksum
    run_frame(8'h02, 8'h41, 0, 1'b0);

    // Full 256-word frame
    data_q.delete();
    for (int i = 0; i < 256; i++) begin
      data_q.push_back(8'(i));
      data_q.push_back(~8'(i));
    end
    run_frame(8'h00, 8'h00, 0, 1'b0);

    // Valid toggling every cycle, 3 words
    data_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    run_frame(8'h03, 8'h07, 1, 1'b0);

    // Reset in the middle of word 1, with its LO byte on offer
    data_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    pulse_start();
    wr_count = 0;
    send_byte(8'h03, 1'b0, 0, 1'b0);
    send_byte(8'h11, 1'b0, 0, 1'b0);
    pend_addr = 8'h00;
    pend_data = 16'h1122;
    send_byte(8'h22, 1'b1, 0, 1'b0);
    send_byte(8'h33, 1'b0, 0, 1'b0);
    bus.in_valid = 1'b1;
    bus.in_byte  = 8'h44;
    #2;
    reset = 1'b1;
    #1;
    chk_eq("mid_rst_ready", 32'(bus.in_ready), 32'd0);
    chk_eq("mid_rst_hold", 32'(bus.cpu_hold), 32'd1);
    chk_eq("mid_rst_wr_en", 32'(bus.wr_en), 32'd0);
    step(1'b0);
    bus.in_valid = 1'b0;
    step(1'b0);
    reset = 1'b0;
    step(1'b0);
    step(1'b0);
    chk_eq("post_rst_ready", 32'(bus.in_ready), 32'd0);
    chk_eq("post_rst_hold", 32'(bus.cpu_hold), 32'd1);
    run_frame(8'h03, 8'h11 ^ 8'h22 ^ 8'h33 ^ 8'h44 ^ 8'h55 ^ 8'h66, 0, 1'b0);

    // Byte offered in IDLE/DONE and a start pulse mid-frame are both ignored
    bus.in_valid = 1'b1;
    bus.in_byte  = 8'hA5;
    step(1'b0);
    step(1'b0);
    chk_eq("idle_ready", 32'(bus.in_ready), 32'd0);
    data_q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    run_frame(8'h02, 8'hDE ^ 8'hAD ^ 8'hBE ^ 8'hEF, 0, 1'b1);

    // Randomized frames with random gaps and occasional corrupted checksums
    for (int f = 0; f < 12; f++) begin
      len = 8'($urandom_range(1, 8));
      data_q.delete();
      x = 8'h00;
      for (int i = 0; i < 2 * int'(len); i++) begin
        data_q.push_back(8'($urandom));
        x = x ^ data_q[i];
      end
      if ($urandom_range(0, 2) == 0) begin
        x = x ^ 8'($urandom_range(1, 255));
      end
      run_frame(len, x, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 3)) step(1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
